sram_1rw1r_port0_ctrl: RTL and testbench

//  Requester-side controller for the 80x64 1RW+1R OpenRAM macro's RW port 0.

---
 rtl/sram_1rw1r_port0_ctrl_if.sv | 26 ++
 rtl/sram_1rw1r_port0_ctrl.sv | 118 +++++++++++
 tb/tb_sram_1rw1r_port0_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw1r_port0_ctrl_if.sv
// Request/response handshake bundle between core logic and the port-0 SRAM controller.
interface sram_1rw1r_port0_ctrl_if #(
    parameter int DATA_WIDTH = 80,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_WMASKS = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_1rw1r_port0_ctrl.sv
// Drives RW port 0 of the 1RW+1R macro from a valid/ready request stream; read data
// returns through a credit-limited response FIFO. Optionally zero-fills the macro after reset.
module sram_1rw1r_port0_ctrl #(
    parameter int DATA_WIDTH    = 80,
    parameter int ADDR_WIDTH    = 6,
    parameter int NUM_WMASKS    = 10,
    parameter int RSP_DEPTH     = 4,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_1rw1r_port0_ctrl_if.slave bus,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] init_addr_reg;
    logic                  init_done_reg;
    logic [1:0]            rd_pipe_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

    logic [CNT_W:0]        credit_used;
    logic                  ready;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Reads still travelling through the macro hold a FIFO slot, so the FIFO can never overflow.
    assign credit_used = {1'b0, count_reg} + (CNT_W+1)'(rd_pipe_reg[0]) + (CNT_W+1)'(rd_pipe_reg[1]);
    assign ready       = init_done_reg && (state_reg == ST_RUN) && (credit_used < (CNT_W+1)'(RSP_DEPTH));
    assign accept      = bus.req_valid && ready;
    assign push        = rd_pipe_reg[1];
    assign pop         = (count_reg != '0) && bus.rsp_ready;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (count_reg != '0);
    assign bus.rsp_rdata = fifo_mem[rd_ptr_reg];
    assign init_done     = init_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_addr_reg <= '0;
            init_done_reg <= 1'b0;
            sram_csb0     <= 1'b1;
            sram_web0     <= 1'b1;
            sram_wmask0   <= '0;
            sram_addr0    <= '0;
            sram_din0     <= '0;
            rd_pipe_reg   <= '0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sram_csb0     <= 1'b0;
                    sram_web0     <= 1'b0;
                    sram_wmask0   <= '1;
                    sram_din0     <= '0;
                    sram_addr0    <= init_addr_reg;
                    init_addr_reg <= init_addr_reg + 1'b1;
                    if (init_addr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    init_done_reg <= 1'b1;
                    if (accept) begin
                        sram_csb0   <= 1'b0;
                        sram_web0   <= ~bus.req_we;
                        sram_wmask0 <= bus.req_wmask;
                        sram_addr0  <= bus.req_addr;
                        sram_din0   <= bus.req_wdata;
                    end else begin
                        sram_csb0 <= 1'b1;
                        sram_web0 <= 1'b1;
                    end
                end
            endcase

            // Stage 0: pins loaded; stage 1: macro sampled; capture dout0 on the following edge.
            rd_pipe_reg <= {rd_pipe_reg[0], accept && !bus.req_we};

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sram_dout0;
        end
    end
endmodule

// File: tb/tb_sram_1rw1r_port0_ctrl.sv
// Directed bench with a behavioural macro model and an in-order response scoreboard.
module tb_sram_1rw1r_port0_ctrl;
    localparam int DW = 80;
    localparam int AW = 6;
    localparam int NM = 10;
    localparam logic [DW-1:0] V5 = 80'h1234_5678_9ABC_DEF0_1122;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_1rw1r_port0_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) bus ();

    logic          init_done;
    logic          sram_csb0;
    logic          sram_web0;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    sram_1rw1r_port0_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .RSP_DEPTH(4), .INIT_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Macro model: pins sampled at posedge, array written / dout driven at negedge.
    logic [DW-1:0] mem [64];
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic [NM-1:0] m_mask;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    initial sram_dout0 = '0;

    always @(posedge clk) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_mask <= sram_wmask0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) begin
                for (int b = 0; b < NM; b++) begin
                    if (m_mask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
                end
            end else begin
                sram_dout0 <= mem[m_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int first_pop = -1;
    int last_pop = -1;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    end

    // Scoreboard monitor: a pop happens at the next posedge whenever valid&ready here.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got=%h exp=none", bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e);
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NM-1:0] m, input logic [DW-1:0] exp, output int waits);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        waits = 0;
        while (1) begin
            @(posedge clk);
            waits++;
            if (bus.req_ready) begin
                if (!we) exp_q.push_back(exp);
                break;
            end
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL req_timeout got=no_accept exp=accept addr=%0d", a);
                break;
            end
        end
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic check_init();
        int n;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("init_pins", DW'({sram_csb0, sram_web0, sram_wmask0, sram_addr0, (sram_din0 == '0)}),
                  DW'({1'b0, 1'b0, 10'h3FF, 6'(i), 1'b1}));
        end
        n = 0;
        while (!init_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("init_done", DW'(init_done), DW'(1));
        check("ready_after_init", DW'(bus.req_ready), DW'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", DW'(exp_q.size()), DW'(0));
    endtask

    function automatic logic [DW-1:0] stream_exp(input int a);
        if (a == 5) return V5;
        if (a == 9) return 80'h0000_0000_0000_0000_00FF;
        return '0;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        int total;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_pins", DW'({sram_csb0, sram_web0, sram_wmask0, sram_addr0}), DW'({1'b1, 1'b1, 10'h0, 6'h0}));
        check("rst_din", sram_din0, '0);
        check("rst_flags", DW'({bus.req_ready, bus.rsp_valid, init_done}), DW'(0));

        // 1: zero-fill
        @(negedge clk) rst_n = 1'b1;
        check_init();

        // 2: full write then read-after-write, 2-cycle latency
        @(posedge clk) #1;
        send(1'b1, 6'd5, V5, 10'h3FF, '0, w);
        send(1'b0, 6'd5, '0, 10'h0, V5, w);
        @(negedge clk);
        @(negedge clk);
        check("lat_before_e2", DW'(bus.rsp_valid), DW'(0));
        @(negedge clk);
        check("lat_after_e2", DW'(bus.rsp_valid), DW'(1));
        drain();

        // 3: partial write, lane 0 only
        @(posedge clk) #1;
        send(1'b1, 6'd9, '1, 10'h001, '0, w);
        send(1'b0, 6'd9, '0, 10'h0, 80'h0000_0000_0000_0000_00FF, w);
        drain();

        // 4: credit limit with response back-pressure
        @(posedge clk) #1;
        bus.rsp_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                send(1'b0, 6'd5, '0, 10'h0, V5, w);
                send(1'b0, 6'd9, '0, 10'h0, 80'h00FF, w);
                send(1'b0, 6'd0, '0, 10'h0, '0, w);
                send(1'b0, 6'd1, '0, 10'h0, '0, w);
                send(1'b0, 6'd2, '0, 10'h0, '0, w);
                send(1'b0, 6'd3, '0, 10'h0, '0, w);
            end
            begin
                repeat (10) @(negedge clk);
                check("credit_accepts", DW'(acc_cnt), DW'(4));
                check("credit_ready_low", DW'(bus.req_ready), DW'(0));
                check("credit_fifo_full", DW'(bus.rsp_valid), DW'(1));
                @(posedge clk) #1;
                bus.rsp_ready = 1'b1;
            end
        join
        drain();
        check("credit_total_accepts", DW'(acc_cnt), DW'(6));

        // 5: streaming reads of the whole array
        @(posedge clk) #1;
        first_pop = -1;
        total = 0;
        for (int i = 0; i < 64; i++) begin
            send(1'b0, 6'(i), '0, 10'h0, stream_exp(i), w);
            total += w;
        end
        drain();
        check("stream_accept_cycles", DW'(total), DW'(64));
        check("stream_no_bubbles", DW'(last_pop - first_pop), DW'(63));

        // 6: reset with reads in flight and FIFO occupied
        @(posedge clk) #1;
        bus.rsp_ready = 1'b0;
        send(1'b0, 6'd5, '0, 10'h0, V5, w);
        send(1'b0, 6'd9, '0, 10'h0, 80'h00FF, w);
        send(1'b0, 6'd5, '0, 10'h0, V5, w);
        send(1'b0, 6'd9, '0, 10'h0, 80'h00FF, w);
        #1;
        check("pre_reset_rsp_valid", DW'(bus.rsp_valid), DW'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("async_rst_csb0", DW'(sram_csb0), DW'(1));
        exp_q.delete();
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check_init();
        @(posedge clk) #1;
        send(1'b1, 6'd7, 80'hA5A5_0000_FFFF_1234_5678, 10'h3FF, '0, w);
        send(1'b0, 6'd7, '0, 10'h0, 80'hA5A5_0000_FFFF_1234_5678, w);
        send(1'b0, 6'd5, '0, 10'h0, '0, w);
        drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
